// File: rtl/temp_seg_display.sv
// Signed 8-bit temperature to BCD via sequential double-dabble, shown on a
// 4-digit multiplexed 7-segment display (sign, hundreds, tens, ones).
module temp_seg_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        SYSCLK,
    input  logic        RST,
    input  logic [7:0]  temp_in,
    input  logic        temp_vld,
    output logic        busy,
    output logic [12:0] bcd,
    output logic [3:0]  digit_sel,
    output logic [6:0]  seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     mag_q, mag_d;
    logic [11:0]    scratch_q, scratch_d;
    logic [2:0]     iter_q, iter_d;
    logic           sign_q, sign_d;
    logic [12:0]    bcd_q, bcd_d;
    logic [CW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]     dig_idx_q, dig_idx_d;
    logic [3:0]     digit_sel_q, digit_sel_d;
    logic [6:0]     seg_q, seg_d;
    logic [11:0]    adj;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    // Leading zeros are blanked; ones digit is always lit.
    function automatic logic [6:0] digit_pattern(input logic [1:0] idx, input logic [12:0] b);
        case (idx)
            2'd0:    digit_pattern = seg_of(b[3:0]);
            2'd1:    digit_pattern = (b[11:4] == 8'd0) ? 7'h00 : seg_of(b[7:4]);
            2'd2:    digit_pattern = (b[11:8] == 4'd0) ? 7'h00 : seg_of(b[11:8]);
            default: digit_pattern = b[12] ? 7'h40 : 7'h00;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_add3
            assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                    scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (temp_vld) begin
                    sign_d    = temp_in[7];
                    mag_d     = temp_in[7] ? (8'd0 - temp_in) : temp_in;
                    scratch_d = 12'd0;
                    iter_d    = 3'd0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                {scratch_d, mag_d} = {adj[10:0], mag_q, 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = {sign_q, scratch_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Segment pattern uses the upcoming digit index so select and pattern change together.
    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dig_idx_d  = dig_idx_q + 2'd1;
        end
        digit_sel_d = 4'b0001 << dig_idx_d;
        seg_d       = digit_pattern(dig_idx_d, bcd_q);
    end

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            mag_q       <= 8'd0;
            scratch_q   <= 12'd0;
            iter_q      <= 3'd0;
            sign_q      <= 1'b0;
            bcd_q       <= 13'd0;
            scan_cnt_q  <= '0;
            dig_idx_q   <= 2'd0;
            digit_sel_q <= 4'b0001;
            seg_q       <= 7'h3F;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            sign_q      <= sign_d;
            bcd_q       <= bcd_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign bcd       = bcd_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_temp_seg_display.sv
// Randomized and directed checks of temp_seg_display against an arithmetic
// model of committed temperature, conversion latency and scan position.
module tb_temp_seg_display;

    localparam int SD = 4;

    logic        SYSCLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  temp_in = 8'd0;
    logic        temp_vld = 1'b0;
    logic        busy;
    logic [12:0] bcd;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    // Model state: committed temperature as an integer, not as BCD.
    int disp_m, disp_prev, pending_m, done_edge, edge_cnt;
    bit busy_m;

    temp_seg_display #(.SCAN_DIV(SD)) dut (
        .SYSCLK   (SYSCLK),
        .RST      (RST),
        .temp_in  (temp_in),
        .temp_vld (temp_vld),
        .busy     (busy),
        .bcd      (bcd),
        .digit_sel(digit_sel),
        .seg      (seg)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [12:0] ref_bcd(input int t);
        int m;
        m = abs_i(t);
        return {(t < 0) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input int idx, input int t);
        int m, h, te, o;
        m  = abs_i(t);
        h  = m / 100;
        te = (m / 10) % 10;
        o  = m % 10;
        case (idx)
            0:       return glyph(o);
            1:       return (h == 0 && te == 0) ? 7'h00 : glyph(te);
            2:       return (h == 0) ? 7'h00 : glyph(h);
            default: return (t < 0) ? 7'h40 : 7'h00;
        endcase
    endfunction

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input bit vld, input logic [7:0] val);
        int idx;
        temp_vld = vld;
        temp_in  = val;
        @(posedge SYSCLK);
        disp_prev = disp_m;
        if (busy_m && edge_cnt == done_edge) begin
            disp_m = pending_m;
            busy_m = 1'b0;
            $display("commit temp=%0d bcd=%h", disp_m, ref_bcd(disp_m));
        end else if (!busy_m && vld) begin
            busy_m    = 1'b1;
            pending_m = $signed(val);
            done_edge = edge_cnt + 9;
        end
        edge_cnt++;
        idx = (edge_cnt / SD) % 4;
        #1;
        temp_vld = 1'b0;
        check("busy", 32'(busy), 32'(busy_m));
        check("bcd", 32'(bcd), 32'(ref_bcd(disp_m)));
        check("digit_sel", 32'(digit_sel), 32'(4'b0001 << idx));
        check("seg", 32'(seg), 32'(ref_seg(idx, disp_prev)));
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        disp_m = 0; disp_prev = 0; busy_m = 1'b0; edge_cnt = 0; done_edge = 0;
        check("rst_busy", 32'(busy), 32'(busy_m));
        check("rst_bcd", 32'(bcd), 32'(ref_bcd(disp_m)));
        check("rst_digit_sel", 32'(digit_sel), 32'h1);
        check("rst_seg", 32'(seg), 32'(ref_seg(0, disp_m)));
        #3;
        RST = 1'b0;
        $display("reset applied");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'd0);
    endtask

    initial begin
        logic [7:0] dir_vals [10];
        dir_vals = '{8'd25, 8'hF9, 8'h80, 8'd100, 8'd0, 8'd127, 8'hFF, 8'd99, 8'd10, 8'hF6};
        disp_m = 0; disp_prev = 0; busy_m = 1'b0; edge_cnt = 0; done_edge = 0; pending_m = 0;

        @(posedge SYSCLK);
        #1;
        do_reset();
        idle(4 * SD + 2);

        foreach (dir_vals[i]) begin
            step(1'b1, dir_vals[i]);
            idle(10 + 4 * SD);
        end

        // Strobes while busy: accept 25, ignore at edges 3 and 9, accept at 10.
        step(1'b1, 8'd25);
        for (int e = 1; e <= 10; e++) step(e == 3 || e == 9 || e == 10, 8'd99);
        idle(10 + 4 * SD);

        // Reset part-way through a conversion of 50, then a clean retry.
        step(1'b1, 8'd25);
        idle(10);
        step(1'b1, 8'd50);
        idle(4);
        do_reset();
        idle(2);
        step(1'b1, 8'd50);
        idle(10 + 4 * SD);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 5) == 0, 8'($urandom));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_seg_display.md
# temp_seg_display

Downstream display stage for the SPI temperature reader. Accepts each 8-bit two's-complement temperature sample (°C) with a one-cycle valid strobe, converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit multiplexed 7-segment display: sign, hundreds, tens, ones. Sits between the SPI read block's `data` output and the board's segment/digit pins.

## Interface
- `SCAN_DIV`, default 4: SYSCLK cycles each digit stays selected; legal range ≥1.
- `SYSCLK` in 1: system clock; all state updates on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `temp_in` in 8: signed two's-complement temperature, -128..127.
- `temp_vld` in 1: one-cycle strobe; `temp_in` is sampled when high and the block is IDLE.
- `busy` out 1: high while a conversion is in progress (state ≠ IDLE).
- `bcd` out 13: committed value `{sign, hundreds[3:0], tens[3:0], ones[3:0]}`, where sign=1 means negative.
- `digit_sel` out 4: one-hot digit enable, active-high. 0001=ones, 0010=tens, 0100=hundreds, 1000=sign.
- `seg` out 7: segment pattern `{g,f,e,d,c,b,a}`, active-high.

## Operation
- **FSM states:** IDLE, CONV, DONE.
- **IDLE:**
  - When `temp_vld`=1: latch sign = `temp_in[7]`. Latch magnitude = `temp_in[7] ? -temp_in : temp_in`, computed 8-bit unsigned, so -128 gives 128.
  - Clear the 12-bit BCD scratch register and the iteration counter, then go to CONV.
- **CONV:** one double-dabble iteration per cycle.
  - Add 3 to each scratch BCD nibble that is ≥5.
  - Shift `{scratch, magnitude}` left by 1.
  - After the 8th iteration, go to DONE.
- **DONE:** copy sign and scratch BCD into the committed display registers (`bcd`) atomically, then go to IDLE.
- **Busy handling:** `temp_vld` seen in CONV or DONE is ignored; there is no queueing.
- **Scan divider:**
  - Counter runs 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0→1→2→3→0 (ones, tens, hundreds, sign).
- **Digit encoding:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Minus = 40; blank = 00.
- **Blanking:**
  - Sign digit shows minus if the committed sign=1, otherwise blank.
  - Hundreds is blank if 0.
  - Tens is blank if hundreds=0 and tens=0.
  - Ones is always shown.
  - Negative zero cannot occur, because -0 = 0 is positive.
- **Registered outputs:** `digit_sel` and `seg` are registered and update on the same edge, so there are no mismatched digit/segment combinations. `seg` is encoded from the next digit index and the committed registers as they stand before that edge.

## Timing
- **Reset values:**
  - State IDLE; `busy`=0; `bcd`=0 (positive).
  - Scan counter 0, digit index 0, `digit_sel`=0001, `seg`=3F.
  - Scratch registers and iteration counter cleared.
- **Accept edge:** call the edge that samples `temp_vld` in IDLE edge 0. State is CONV after it, and `busy`=1 after edge 0.
- **Conversion edges:**
  - Edges 1..8 perform iterations 1..8.
  - Edge 9 (in DONE) commits `bcd` and returns to IDLE; `busy`=0 after edge 9.
  - The earliest next accepted strobe is at edge 10.
- **Latency:**
  - `bcd` changes 9 cycles after the accept edge.
  - `seg` reflects the new value from edge 10 onward, on whichever digit is selected.
- **Dwell:** each digit is held exactly SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles. SCAN_DIV=1 advances the digit every cycle.
- **Reset mid-conversion:** asynchronous return to reset values. A partial result is never committed, and `bcd` returns to 0.
- **Arithmetic width:** the scratch register is 12 bits. The maximum magnitude of 128 fits as 1/2/8, so no overflow is possible.

## Test plan
- **Reset:** assert `RST` asynchronously mid-cycle → `busy`=0, `bcd`=0, `digit_sel`=0001, `seg`=3F immediately. With SCAN_DIV=4, `digit_sel` then cycles 0001→0010→0100→1000 every 4 cycles, with `seg` = 3F, 00, 00, 00.
- **Positive value:** `temp_in`=25 (0x19), strobe → `busy` high for 9 cycles, `bcd`=0_0000_0010_0101. Scan shows ones=6D, tens=5B, hundreds=00, sign=00.
- **Negative value:** `temp_in`=-7 (0xF9) → `bcd`=1_0000_0000_0111. Scan shows ones=07, tens=00, hundreds=00, sign=40.
- **Extreme values:**
  - -128 (0x80) → `bcd`=1_0001_0010_1000, segments 7F/5B/06/40.
  - 100 (0x64) → segments 3F/3F/06/00; the interior tens zero is shown.
- **Busy collision:** strobe 25, then strobe 99 at edges 3 and 9 → both ignored, final `bcd`=25. A third strobe of 99 at edge 10 → `bcd`=99 after edge 19.
- **Reset mid-conversion:** display holds 25; strobe 50, assert `RST` at edge 5 → `bcd`=0, `busy`=0. After release, a fresh strobe of 50 converts normally in 9 cycles.
